uart_hex_loader: RTL and testbench
==================================

UART_HEX_LOADER -- requirements
Module: uart_hex_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434 (50 MHz / 115200 baud), meaning clk cycles per UART bit; legal range >= 4.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_rx  input  1  asynchronous UART serial line, 8N1, LSB first, idle high.
REQ-005 SHALL have port o_data  output  16  display word; four hex nibbles, [15:12] most significant; drives the display driver's 16-bit data input directly.
REQ-006 SHALL have port o_upd  output  1  one-cycle pulse: o_data changed or was cleared by a received character.
REQ-007 SHALL have port o_frame_err  output  1  one-cycle pulse: received byte had stop bit = 0.
REQ-008 SHALL have port o_busy  output  1  high while the receiver is in any state other than IDLE.

Function
REQ-009 SHALL pass i_rx through a 2-flop synchronizer; the synchronizer flops reset to 1; all FSM logic uses the synchronized value rx_s.
REQ-010 SHALL implement FSM states IDLE, START, DATA, STOP, with a bit-timing counter of width $clog2(CLKS_PER_BIT) and a 3-bit bit index.
REQ-011 IDLE: when rx_s = 0, go to START with counter cleared; otherwise stay.
REQ-012 START: after CLKS_PER_BIT/2 cycles (integer division), sample rx_s; if 0, go to DATA with counter cleared; if 1 (glitch), return to IDLE with no output pulse.
REQ-013 DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register LSB-first; after the 8th sample, go to STOP.
REQ-014 STOP: after CLKS_PER_BIT cycles, sample rx_s and return to IDLE on the same edge; a new start bit is accepted from the next cycle onward.
REQ-015 On a stop sample = 0, SHALL assert o_frame_err for exactly one cycle after the sampling edge, discard the byte, and leave o_data unchanged.
REQ-016 On a stop sample = 1, SHALL decode the byte at the sampling edge.
REQ-017 Decode, hex digit: bytes 0x30-0x39 ('0'-'9') map to values 0-9; 0x41-0x46 ('A'-'F') and 0x61-0x66 ('a'-'f') map to values A-F; o_data <= {o_data[11:0], nibble}; the upper nibble is discarded (wrap, no saturation).
REQ-018 Decode, clear: byte 0x58 or 0x78 ('X'/'x') SHALL set o_data <= 16'h0000.
REQ-019 Decode, other: every other byte SHALL be ignored; no change to o_data and no pulse.
REQ-020 o_upd SHALL be high for exactly the one cycle after an edge that updated or cleared o_data; a clear pulses o_upd even if o_data was already 0.
REQ-021 o_upd and o_frame_err SHALL never be high in the same cycle.
REQ-022 o_data SHALL be registered and change only on decode edges, so it stays glitch-free for the display.
REQ-023 o_busy SHALL be combinationally derived from the state register (state != IDLE).
REQ-024 Latency: from the i_rx falling edge of the start bit to o_upd = 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (±1 cycle for input phase).

Reset
REQ-025 While rst_n = 0: o_data = 16'h0000, o_upd = 0, o_frame_err = 0, FSM = IDLE (so o_busy = 0), counters and shift register = 0, synchronizer flops = 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no pulses; after release, the block SHALL wait for the next falling edge of rx_s.

Verification (CLKS_PER_BIT = 8)
REQ-027 Send '1','2','a','F' (0x31, 0x32, 0x61, 0x46) -> four o_upd pulses; o_data = 16'h12AF.
REQ-028 Send '1','2','3','4','5' -> o_data = 16'h2345 (wrap); then send 'x' -> o_data = 16'h0000 with one o_upd pulse.
REQ-029 Send 0x31 with stop bit = 0 -> one o_frame_err pulse, no o_upd pulse, o_data unchanged; the next valid '7' is received correctly.
REQ-030 Drive i_rx low for 2 cycles, then high -> FSM returns to IDLE after START, no pulses; o_busy is high for at most CLKS_PER_BIT/2 + 1 cycles.
REQ-031 Assert rst_n low during the DATA bits of '9' -> outputs return to reset values, no o_upd pulse; a following 'C' gives o_data = 16'h000C.
REQ-032 Send '5','G','6' (0x47 is ignored) -> exactly two o_upd pulses; o_data = 16'h0056.

Source files
------------

// File: rtl/uart_hex_loader.sv
// rtl/uart_hex_loader.sv - UART 8N1 receiver that shifts received hex digits into a 16-bit display word
//
// Ports:
//   clk          system clock, rising-edge
//   rst_n        asynchronous active-low reset
//   i_rx         UART serial line (8N1, LSB first, idle high), asynchronous to clk
//   o_data       display word, four hex nibbles, [15:12] most significant
//   o_upd        one-cycle pulse when o_data was shifted or cleared
//   o_frame_err  one-cycle pulse when a byte arrived with a low stop bit
//   o_busy       receiver is not idle
module uart_hex_loader #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_rx,
   output logic [15:0] o_data,
   output logic        o_upd,
   output logic        o_frame_err,
   output logic        o_busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   // Terminal counts: a full bit period, and half a bit to land mid start bit.
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shift;
   logic          rx_m;
   logic          rx_s;
   logic [4:0]    dec;
   logic          is_clear;

   // {valid, nibble} for ASCII hex digits; letters map via low nibble + 9.
   function automatic logic [4:0] decode(input logic [7:0] b);
      if (b >= 8'h30 && b <= 8'h39)
         return {1'b1, b[3:0]};
      if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
         return {1'b1, b[3:0] + 4'd9};
      return 5'b0_0000;
   endfunction

   assign dec      = decode(shift);
   assign is_clear = (shift == 8'h58) || (shift == 8'h78);
   assign o_busy   = (state != IDLE);

   // Idle-high synchronizer so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= i_rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= 3'd0;
         shift       <= 8'h00;
         o_data      <= 16'h0000;
         o_upd       <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         o_upd       <= 1'b0;
         o_frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == HALF) begin
                  cnt   <= '0;
                  idx   <= 3'd0;
                  // A line that is high again mid start bit was a glitch.
                  state <= rx_s ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == FULL) begin
                  cnt   <= '0;
                  shift <= {rx_s, shift[7:1]};
                  idx   <= idx + 1'b1;
                  if (idx == 3'd7)
                     state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == FULL) begin
                  cnt   <= '0;
                  state <= IDLE;
                  if (!rx_s) begin
                     o_frame_err <= 1'b1;
                  end else if (is_clear) begin
                     o_data <= 16'h0000;
                     o_upd  <= 1'b1;
                  end else if (dec[4]) begin
                     o_data <= {o_data[11:0], dec[3:0]};
                     o_upd  <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_hex_loader.sv
// tb/tb_uart_hex_loader.sv - randomized self-checking bench for uart_hex_loader against a byte-level model
module tb_uart_hex_loader;

   localparam int CPB = 8;
   // Start-bit fall to o_upd: 2 sync + CPB/2 + 9*CPB + 1.
   localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_rx;
   logic [15:0] o_data;
   logic        o_upd;
   logic        o_frame_err;
   logic        o_busy;

   uart_hex_loader #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_rx       (i_rx),
      .o_data     (o_data),
      .o_upd      (o_upd),
      .o_frame_err(o_frame_err),
      .o_busy     (o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          ferr;
      logic [15:0] data;
      int          due;
   } ev_t;

   ev_t         expq[$];
   logic [15:0] pend  = 16'h0000;
   logic [15:0] shown = 16'h0000;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   int          upd_cnt = 0;
   int          ferr_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic chk_win(input string name, input int act, input int due);
      checks++;
      if (act < due - 1 || act > due + 1) begin
         failures++;
         $display("FAIL %s actual_cycle=%0d required_cycle=%0d+-1", name, act, due);
      end
   endtask

   function automatic bit mdl_hex(input logic [7:0] b, output logic [3:0] v);
      int c;
      c = int'(b);
      v = 4'h0;
      if (c >= 48 && c <= 57)  begin v = 4'(c - 48); return 1'b1; end
      if (c >= 65 && c <= 70)  begin v = 4'(c - 55); return 1'b1; end
      if (c >= 97 && c <= 102) begin v = 4'(c - 87); return 1'b1; end
      return 1'b0;
   endfunction

   // Compare process: every pulse must match the next expected event in time and value.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_data", o_data, 0);
         chk("rst_upd", o_upd, 0);
         chk("rst_ferr", o_frame_err, 0);
         chk("rst_busy", o_busy, 0);
      end else begin
         chk("upd_ferr_excl", o_upd & o_frame_err, 0);
         if (o_upd) begin
            upd_cnt++;
            if (expq.size() == 0 || expq[0].ferr) begin
               chk("spurious_upd", 1, 0);
            end else begin
               chk_win("upd_latency", cyc, expq[0].due);
               chk("upd_data", o_data, expq[0].data);
               shown = expq[0].data;
               void'(expq.pop_front());
            end
         end else if (o_frame_err) begin
            ferr_cnt++;
            if (expq.size() == 0 || !expq[0].ferr) begin
               chk("spurious_ferr", 1, 0);
            end else begin
               chk_win("ferr_latency", cyc, expq[0].due);
               void'(expq.pop_front());
            end
         end else if (expq.size() > 0 && cyc > expq[0].due + 1) begin
            chk(expq[0].ferr ? "missing_ferr" : "missing_upd", 0, 1);
            void'(expq.pop_front());
         end
         chk("data_hold", o_data, shown);
      end
   end

   task automatic idle(input int n);
      i_rx = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Drives nper bit periods of {stop, data, start}; nper < 10 truncates the frame.
   task automatic drive_frame(input logic [7:0] b, input bit stop, input int nper);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < nper; i++) begin
         i_rx = f[i];
         repeat (CPB) @(posedge clk);
         #2;
      end
      i_rx = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop);
      ev_t        e;
      logic [3:0] v;
      bit         hit;
      e.due  = cyc + LAT;
      e.ferr = 1'b0;
      e.data = pend;
      hit    = 1'b1;
      if (!stop) begin
         e.ferr = 1'b1;
      end else if (b == "x" || b == "X") begin
         pend   = 16'h0000;
         e.data = pend;
      end else if (mdl_hex(b, v)) begin
         pend   = {pend[11:0], v};
         e.data = pend;
      end else begin
         hit = 1'b0;
      end
      if (hit) expq.push_back(e);
      drive_frame(b, stop, 10);
      idle($urandom_range(0, 4));
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      i_rx  = 1'b1;
      expq.delete();
      pend  = 16'h0000;
      shown = 16'h0000;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout cycle=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int u0, f0, bc;
      logic [7:0] b;
      int r;
      i_rx  = 1'b1;
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      do_reset(4);
      idle(3);

      // Four digits build a word.
      u0 = upd_cnt;
      send_byte(8'h31, 1); send_byte(8'h32, 1); send_byte(8'h61, 1); send_byte(8'h46, 1);
      idle(3);
      chk("r27_pulses", upd_cnt - u0, 4);
      chk("r27_data", o_data, 16'h12AF);

      // Fifth digit wraps out the oldest nibble, then clear.
      send_byte("1", 1); send_byte("2", 1); send_byte("3", 1); send_byte("4", 1); send_byte("5", 1);
      idle(3);
      chk("r28_wrap", o_data, 16'h2345);
      u0 = upd_cnt;
      send_byte("x", 1);
      idle(3);
      chk("r28_clear", o_data, 16'h0000);
      chk("r28_clear_pulse", upd_cnt - u0, 1);

      // Framing error.
      u0 = upd_cnt; f0 = ferr_cnt;
      send_byte(8'h31, 0);
      idle(3);
      chk("r29_ferr_pulse", ferr_cnt - f0, 1);
      chk("r29_no_upd", upd_cnt - u0, 0);
      chk("r29_data", o_data, 16'h0000);
      send_byte("7", 1);
      idle(3);
      chk("r29_recover", o_data, 16'h0007);

      // Two-cycle glitch.
      u0 = upd_cnt; f0 = ferr_cnt;
      i_rx = 1'b0;
      repeat (2) begin @(posedge clk); #2; end
      i_rx = 1'b1;
      bc = 0;
      repeat (20) begin
         @(negedge clk);
         if (o_busy) bc++;
      end
      @(posedge clk);
      #2;
      chk("r30_busy_bounded", (bc >= 1 && bc <= CPB / 2 + 1), 1);
      chk("r30_no_pulses", (upd_cnt - u0) + (ferr_cnt - f0), 0);
      chk("r30_data", o_data, 16'h0007);

      // Reset during the data bits of '9'.
      u0 = upd_cnt;
      drive_frame("9", 1, 4);
      do_reset(3);
      idle(CPB * 10);
      chk("r31_no_upd", upd_cnt - u0, 0);
      chk("r31_data_reset", o_data, 16'h0000);
      send_byte("C", 1);
      idle(3);
      chk("r31_after", o_data, 16'h000C);

      // Non-hex byte is ignored.
      send_byte("x", 1);
      idle(3);
      u0 = upd_cnt;
      send_byte("5", 1); send_byte(8'h47, 1); send_byte("6", 1);
      idle(3);
      chk("r32_pulses", upd_cnt - u0, 2);
      chk("r32_data", o_data, 16'h0056);

      // Randomized traffic.
      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(0, 9);
         if (r <= 3) begin
            r = $urandom_range(0, 21);
            if (r < 10)      b = 8'(8'h30 + r);
            else if (r < 16) b = 8'(8'h41 + r - 10);
            else             b = 8'(8'h61 + r - 16);
            send_byte(b, 1);
         end else if (r == 4) begin
            send_byte(($urandom_range(0, 1) != 0) ? 8'h58 : 8'h78, 1);
         end else if (r == 5) begin
            send_byte(8'($urandom_range(0, 255)), 0);
         end else begin
            send_byte(8'($urandom_range(0, 255)), 1);
         end
      end
      idle(5);
      chk("final_queue_empty", expq.size(), 0);
      chk("final_data", o_data, pend);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
